// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async FIFO read side.
// Holds data/address width defaults, the data word type and a count-width helper.
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int BUF_DEPTH_DEF = 4;

  typedef logic [DATA_SIZE_DEF-1:0] fifo_data_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy width for the default buffer depth.
  localparam int CNT_W = $clog2(BUF_DEPTH_DEF) + 1;

endpackage

// File: rtl/rd_out_buf.sv
// Prefetch ring buffer: DEPTH registers with rd/wr pointers and an occupancy count.
// Ports: clk, rst_n (sync, active low), push/push_data, pop, head, count.
module rd_out_buf
  import fifo_pkg::*;
#(
  parameter int DW = DATA_SIZE_DEF,
  parameter int DEPTH = BUF_DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;

  // Pops on an empty buffer are ignored.
  assign pop_ok = pop & (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/rd_stream_adapter.sv
// Read-side stream adapter: turns rEmpty/rinc into a FWFT valid/ready stream.
// Ports: rclk, rrst, rEmpty, rdata, rinc, m_data, m_valid, m_ready, buf_count.
module rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int BUF_DEPTH = 4,
  localparam int CW = cnt_w(BUF_DEPTH)
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CW-1:0]        buf_count
);

  logic          pend;
  logic [CW-1:0] count;
  logic [CW:0]   occ;

  // Credit counts words already buffered plus the one in flight from
  // the RAM, so the ring can never be pushed while full.
  assign occ  = {1'b0, count} + (CW+1)'(pend);
  assign rinc = rrst & ~rEmpty & (occ < (CW+1)'(BUF_DEPTH));

  // RAM read is registered: data for a rinc arrives one cycle later.
  always_ff @(posedge rclk) begin
    if (!rrst) begin
      pend <= 1'b0;
    end else begin
      pend <= rinc;
    end
  end

  rd_out_buf #(
    .DW    (DATA_SIZE),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst),
    .push      (pend),
    .push_data (rdata),
    .pop       (m_ready),
    .head      (m_data),
    .count     (count)
  );

  assign m_valid   = (count != '0);
  assign buf_count = count;

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Directed bench for rd_stream_adapter (BUF_DEPTH=4, DATA_SIZE=8).
// Vector table for reset/first-word/gap, hand sequences for the rest.
module tb_rd_stream_adapter;

  logic       rclk = 1'b0;
  logic       rrst = 1'b0;
  logic       rEmpty = 1'b0;
  logic [7:0] rdata = 8'hEE;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [2:0] buf_count;

  int total = 0;
  int bad = 0;
  int abad = 0;
  logic started = 1'b0;

  always #5 rclk = ~rclk;

  rd_stream_adapter #(
    .DATA_SIZE (8),
    .BUF_DEPTH (4)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rEmpty    (rEmpty),
    .rdata     (rdata),
    .rinc      (rinc),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .buf_count (buf_count)
  );

  // Buffer must never receive a word while already full.
  always @(posedge rclk) begin
    if (started && rrst === 1'b1 && dut.pend === 1'b1) begin
      assert (buf_count != 3'd4)
      else begin
        abad++;
        $display("FAIL push_full: buf_count=%0d pend=1", buf_count);
      end
    end
  end

  typedef struct {
    logic       rrst;
    logic       re;
    logic [7:0] rd;
    logic       mr;
    logic       er;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] en;
    logic       dchk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [7:0] d,
                              logic m, logic xr, logic xv,
                              logic [7:0] xd, logic [2:0] xn,
                              logic dc);
    vec_t v;
    v.rrst = r; v.re = e; v.rd = d; v.mr = m;
    v.er = xr; v.ev = xv; v.ed = xd; v.en = xn; v.dchk = dc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge rclk);
  endtask

  task automatic do_reset();
    tick();
    rrst = 1'b0; rEmpty = 1'b1; m_ready = 1'b0; rdata = 8'hEE;
    #1;
    chk("rst_rinc", 32'(rinc), 32'd0);
  endtask

  int pulses;
  int idx;
  int got;
  int first;
  int last;
  int issued;
  logic prev;

  initial begin
    // cycles 0..2: reset held, rEmpty low
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 8'hEE, 0, 0, 0, 8'h00, 0, 1));
    // cycles 3..9: idle, empty
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1, 1, 8'hEE, 0, 0, 0, 8'h00, 0, 1));
    // cycle 10: rEmpty falls -> rinc
    vecs.push_back(mk(1, 0, 8'hEE, 0, 1, 0, 8'h00, 0, 1));
    // cycle 11: data returns, rEmpty back high
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 8'h00, 0, 1));
    // cycles 12..16: valid, held stable under backpressure
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 1, 8'hA5, 1, 1));
    // cycle 17: consumer takes it
    vecs.push_back(mk(1, 1, 8'h3C, 1, 0, 1, 8'hA5, 1, 1));
    // cycle 18: empty, m_ready ignored, new rinc
    vecs.push_back(mk(1, 0, 8'hEE, 1, 1, 0, 8'h00, 0, 0));
    // cycle 19: rEmpty rises right after rinc, word in flight
    vecs.push_back(mk(1, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 0));
    // cycles 20..21: in-flight word shows up, no more rinc
    vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 1, 8'h5A, 1, 1));
    vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 1, 8'h5A, 1, 1));
    vecs.push_back(mk(1, 1, 8'h3C, 1, 0, 1, 8'h5A, 1, 1));
    vecs.push_back(mk(1, 1, 8'h3C, 1, 0, 0, 8'h00, 0, 0));

    started = 1'b1;
    foreach (vecs[i]) begin
      tick();
      rrst = vecs[i].rrst; rEmpty = vecs[i].re;
      rdata = vecs[i].rd; m_ready = vecs[i].mr;
      #1;
      chk($sformatf("v%0d_rinc", i), 32'(rinc), 32'(vecs[i].er));
      chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_count", i), 32'(buf_count), 32'(vecs[i].en));
      if (vecs[i].dchk)
        chk($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].ed));
    end

    // Backpressure: continuous data, consumer stalled.
    do_reset();
    pulses = 0; idx = 0; prev = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      rrst = 1'b1; rEmpty = 1'b0; m_ready = 1'b0;
      rdata = prev ? 8'(8'h10 + idx) : 8'hEE;
      if (prev) idx++;
      #1;
      if (rinc) pulses++;
      prev = rinc;
    end
    chk("bp_pulses", 32'(pulses), 32'd4);
    chk("bp_count", 32'(buf_count), 32'd4);
    chk("bp_rinc_end", 32'(rinc), 32'd0);
    chk("bp_head", 32'(m_data), 32'h10);
    // Drain in order.
    for (int k = 0; k < 4; k++) begin
      tick();
      rEmpty = 1'b1; m_ready = 1'b1; rdata = 8'hEE;
      #1;
      chk($sformatf("bp_drain%0d", k), 32'(m_data), 32'(8'h10 + k));
      chk($sformatf("bp_dvalid%0d", k), 32'(m_valid), 32'd1);
    end
    tick();
    m_ready = 1'b0;
    #1;
    chk("bp_empty", 32'(buf_count), 32'd0);

    // Streaming: 16 words, consumer always ready.
    do_reset();
    idx = 0; issued = 0; got = 0; first = -1; last = -1; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      rrst = 1'b1; m_ready = 1'b1;
      rdata = prev ? 8'(idx) : 8'hEE;
      if (prev) idx++;
      rEmpty = (issued >= 16);
      #1;
      if (m_valid) begin
        if (first < 0) first = c;
        if (last >= 0 && last != c - 1)
          chk("st_gap", 32'(c), 32'(last + 1));
        chk($sformatf("st_data%0d", got), 32'(m_data), 32'(got));
        got++;
        last = c;
      end
      prev = rinc;
      if (rinc) issued++;
    end
    chk("st_words", 32'(got), 32'd16);
    chk("st_first", 32'(first), 32'd2);
    chk("st_span", 32'(last - first), 32'd15);

    // Reset with count=3 and a word in flight.
    do_reset();
    idx = 0; prev = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      rrst = 1'b1; rEmpty = 1'b0; m_ready = 1'b0;
      rdata = prev ? 8'(8'h40 + idx) : 8'hEE;
      if (prev) idx++;
      #1;
      prev = rinc;
    end
    tick();
    rrst = 1'b0; rEmpty = 1'b1; rdata = 8'h43;
    #1;
    chk("mr_count_pre", 32'(buf_count), 32'd3);
    chk("mr_pend_rinc", 32'(rinc), 32'd0);
    tick();
    rrst = 1'b1; rdata = 8'h77;
    #1;
    chk("mr_count0", 32'(buf_count), 32'd0);
    chk("mr_valid0", 32'(m_valid), 32'd0);
    chk("mr_rinc0", 32'(rinc), 32'd0);
    tick();
    rEmpty = 1'b0; rdata = 8'hEE;
    #1;
    chk("mr_rinc1", 32'(rinc), 32'd1);
    chk("mr_count1", 32'(buf_count), 32'd0);
    tick();
    rEmpty = 1'b1; rdata = 8'h99;
    #1;
    chk("mr_valid1", 32'(m_valid), 32'd0);
    tick();
    rdata = 8'hEE;
    #1;
    chk("mr_valid2", 32'(m_valid), 32'd1);
    chk("mr_data2", 32'(m_data), 32'h99);
    chk("mr_count2", 32'(buf_count), 32'd1);

    tick();
    bad += abad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rd_stream_adapter.md
Name: rd_stream_adapter

Overview:
Read-side output stage of the async FIFO, in the rclk domain directly downstream of the read pointer handler and FIFO memory. It consumes rEmpty and the memory read data, and drives rinc. It converts the empty/increment interface into a valid/ready stream with first-word-fall-through, using a small prefetch buffer and a credit check so the buffer never overflows.

Parameters:
DATA_SIZE, 8, width of FIFO data word.
BUF_DEPTH, 4, prefetch buffer entries. Must be a power of 2 and ≥2. ≥3 is required for one word per cycle sustained throughput.

Ports:
rclk  input  1  read-domain clock; all state updates on rising edge.
rrst  input  1  synchronous active-low reset, sampled on rising edge of rclk.
rEmpty  input  1  registered empty flag from the read pointer handler.
rdata  input  DATA_SIZE  FIFO memory read data; valid in the cycle after the rinc cycle (registered RAM read).
rinc  output  1  read increment to the read pointer handler.
m_data  output  DATA_SIZE  stream data, equal to the buffer head entry.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready from the consumer.
buf_count  output  $clog2(BUF_DEPTH)+1  current buffer occupancy.

Behaviour:
- Reset (rrst low at an rclk edge):
  - count, rd_ptr, wr_ptr, pend and all storage entries go to 0.
  - Outputs after reset: m_valid=0, m_data=0, buf_count=0.
  - rinc is combinationally forced to 0 while rrst is low.
- Credit and rinc:
  - rinc = rrst & ~rEmpty & ((count + pend) < BUF_DEPTH).
  - The credit check uses registered state only. There is no combinational path from m_ready to rinc.
- pend register: pend <= rinc. Every rinc is accepted by the handler because it is gated by ~rEmpty.
- Push: when pend=1, rdata is written to buf[wr_ptr] and wr_ptr increments, wrapping modulo BUF_DEPTH.
- Pop: when m_valid & m_ready, rd_ptr increments, wrapping modulo BUF_DEPTH.
- count next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- Stream outputs: m_valid = (count != 0); m_data = buf[rd_ptr]. buf_count = count.
- Stream stability: once m_valid is high, m_valid stays high and m_data stays stable until a cycle with m_ready=1.
- Latency: if rEmpty is low in cycle T with credit available, then rinc=1 in T, data is captured at the end of T+1, and m_valid=1 in T+2.
- Full buffer: count + pend ≤ BUF_DEPTH is invariant. Push into a full buffer is impossible by construction and is covered by an assertion in the bench.
- Empty: with count=0, m_ready is ignored and no pop occurs.
- rEmpty rising while pend=1: the in-flight word is still pushed. rEmpty only blocks new rinc.
- Reset mid-operation: an in-flight word returning in the cycle after reset is discarded, because pend=0. The buffer contents are lost.
- Throughput:
  - BUF_DEPTH ≥ 3 with m_ready held high gives one word per cycle.
  - BUF_DEPTH = 2 gives one word per two cycles.
- Ordering: words are delivered strictly in FIFO read order. No reordering and no duplication.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_SIZE and ADDR_SIZE defaults;
  - a data word typedef fifo_data_t;
  - a helper localparam for the count width, $clog2(BUF_DEPTH)+1.
- One sub-module, rd_out_buf: the BUF_DEPTH-entry register ring with rd_ptr/wr_ptr/count, push/pop inputs and head/count outputs.
- The top level holds the pend register and the credit/rinc logic.

Test Plan:
- Reset: rEmpty=0, rrst held low 3 cycles → rinc=0 throughout; m_valid=0, buf_count=0, m_data=0 after the first rising edge with rrst low.
- First word: rEmpty falls in cycle 10, rdata=0xA5 in cycle 11, m_ready=0 → rinc=1 in cycle 10; m_valid=1 and m_data=0xA5 from cycle 12; hold 5 cycles stable.
- Backpressure: rEmpty=0 continuously, m_ready=0, BUF_DEPTH=4 → exactly 4 rinc pulses total; buf_count reaches 4 and holds; rinc stays 0 afterwards.
- Streaming: 16 words 0x00..0x0F available, m_ready=1, BUF_DEPTH=4 → after 2-cycle latency, m_valid stays high 16 consecutive cycles with values 0x00..0x0F in order.
- Empty gap: rEmpty rises in the cycle after a rinc → the in-flight word still appears on m_data; no further rinc until rEmpty falls again.
- Reset mid-stream: buf_count=3 and pend=1, rrst low one cycle → buf_count=0, m_valid=0 next cycle; the word returning on rdata is not delivered.
